multi_time_display: RTL and testbench

Parametrised time display back end for the alarm clock. It takes the current 24 h BCD time, converts it to 12 h AM/PM format when requested, and multiplexes it onto a common-anode 7-segment bank of 4 or 6 digits. It adds a blinking edit-field highlight, a blinking colon, and 12 h leading-zero blanking. It also drives an LED bank with an AM/PM indicator and a rotating alarm chaser. It sits between the timekeeping/alarm core and the board pins, replacing the fixed 8-LED / 16-bit seg7s display path.

---
 rtl/multi_time_display.sv | 204 ++++++++++++++++++++
 tb/tb_multi_time_display.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_time_display.sv
// Time display back end: 24h/12h conversion, multiplexed common-anode 7-segment scan,
// edit-field and colon blinking, and an LED bank with AM/PM indicator and alarm chaser.
module multi_time_display #(
  parameter int unsigned N_DIGITS  = 6,
  parameter int unsigned N_LEDS    = 8,
  parameter int unsigned SCAN_DIV  = 100000,
  parameter int unsigned BLINK_DIV = 50000000,
  parameter int unsigned STEP_DIV  = 12500000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                mod12_24,
  input  logic                alarm,
  input  logic [1:0]          edit_field,
  input  logic [23:0]         time_bcd,
  output logic [N_DIGITS-1:0] anodes,
  output logic [7:0]          segments,
  output logic [N_LEDS-1:0]   leds
);

  localparam int unsigned KW     = $clog2(N_DIGITS);
  localparam int unsigned PW     = $clog2(N_LEDS);
  localparam int unsigned ScanW  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned BlinkW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int unsigned StepW  = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  // Field index 0 = S0 ... 5 = H1; a 4-digit bank starts scanning at M0.
  localparam logic [2:0]  FOff   = (N_DIGITS == 4) ? 3'd2 : 3'd0;

  if (!(N_DIGITS == 4 || N_DIGITS == 6)) begin : g_bad_n_digits
    $error("multi_time_display: N_DIGITS must be 4 or 6");
  end
  if (N_LEDS < 2) begin : g_bad_n_leds
    $error("multi_time_display: N_LEDS must be at least 2");
  end

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      4'hF: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Stage 1 state
  logic [3:0] h1_q, h0_q, m1_q, m0_q, s1_q, s0_q;
  logic [3:0] h1_d, h0_d;
  logic       pm_q, pm_d, mode_q;

  // Stage 2 / output state
  logic [N_DIGITS-1:0] anodes_q, anodes_d;
  logic [7:0]          segments_q, segments_d;
  logic [N_LEDS-1:0]   leds_q, leds_d;

  // Timebase and chaser state
  logic [KW-1:0]     k_q, k_d;
  logic [ScanW-1:0]  scan_cnt_q, scan_cnt_d;
  logic [BlinkW-1:0] blink_cnt_q, blink_cnt_d;
  logic              blink_q, blink_d;
  logic [StepW-1:0]  step_cnt_q, step_cnt_d;
  logic [PW-1:0]     p_q, p_d;
  logic              alarm_q;

  // 12h conversion stays in BCD: only the hour tens/units nibbles are adjusted.
  always_comb begin
    h1_d = time_bcd[23:20];
    h0_d = time_bcd[19:16];
    pm_d = 1'b0;
    if (mod12_24) begin
      if (time_bcd[23:20] == 4'd0 && time_bcd[19:16] == 4'd0) begin
        h1_d = 4'd1;
        h0_d = 4'd2;
      end else if (time_bcd[23:20] == 4'd1 && time_bcd[19:16] == 4'd2) begin
        pm_d = 1'b1;
      end else if (time_bcd[23:20] == 4'd1 && time_bcd[19:16] > 4'd2) begin
        h1_d = 4'd0;
        h0_d = time_bcd[19:16] - 4'd2;
        pm_d = 1'b1;
      end else if (time_bcd[23:20] == 4'd2 && time_bcd[19:16] < 4'd2) begin
        h1_d = 4'd0;
        h0_d = time_bcd[19:16] + 4'd8;
        pm_d = 1'b1;
      end else if (time_bcd[23:20] == 4'd2) begin
        h1_d = 4'd1;
        h0_d = time_bcd[19:16] - 4'd2;
        pm_d = 1'b1;
      end
    end
  end

  // Timebase: digit scan, blink phase, chaser step
  always_comb begin
    scan_cnt_d  = scan_cnt_q + 1'b1;
    k_d         = k_q;
    blink_cnt_d = blink_cnt_q + 1'b1;
    blink_d     = blink_q;
    step_cnt_d  = step_cnt_q;
    p_d         = p_q;
    if (scan_cnt_q == ScanW'(SCAN_DIV - 1)) begin
      scan_cnt_d = '0;
      k_d        = (k_q == KW'(N_DIGITS - 1)) ? '0 : k_q + 1'b1;
    end
    if (blink_cnt_q == BlinkW'(BLINK_DIV - 1)) begin
      blink_cnt_d = '0;
      blink_d     = ~blink_q;
    end
    // Holding p and the step counter at zero while idle covers both edge cases.
    if (!alarm || !alarm_q) begin
      step_cnt_d = '0;
      p_d        = '0;
    end else if (step_cnt_q == StepW'(STEP_DIV - 1)) begin
      step_cnt_d = '0;
      p_d        = (p_q == PW'(N_LEDS - 1)) ? '0 : p_q + 1'b1;
    end else begin
      step_cnt_d = step_cnt_q + 1'b1;
    end
  end

  logic [2:0] fld;
  logic [3:0] digit;
  logic       in_edit, dp_on, blank;

  always_comb begin
    fld = 3'(k_q) + FOff;
    case (fld)
      3'd0:    digit = s0_q;
      3'd1:    digit = s1_q;
      3'd2:    digit = m0_q;
      3'd3:    digit = m1_q;
      3'd4:    digit = h0_q;
      default: digit = h1_q;
    endcase
    in_edit = (edit_field == 2'd1 && fld >= 3'd4) ||
              (edit_field == 2'd2 && (fld == 3'd2 || fld == 3'd3)) ||
              (edit_field == 2'd3 && fld <= 3'd1);
    // Colon dots sit on H0 and M0; steady while editing.
    dp_on = (fld == 3'd2 || fld == 3'd4) && (!blink_q || edit_field != 2'd0);
    blank = (blink_q && in_edit) || (mode_q && fld == 3'd5 && h1_q == 4'd0);
    segments_d = blank ? 8'hFF : {~dp_on, seg7(digit)};
    anodes_d   = ~(N_DIGITS'(1) << k_q);
    leds_d     = alarm_q ? (N_LEDS'(1) << p_q) : N_LEDS'(pm_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      h1_q        <= '0;
      h0_q        <= '0;
      m1_q        <= '0;
      m0_q        <= '0;
      s1_q        <= '0;
      s0_q        <= '0;
      pm_q        <= 1'b0;
      mode_q      <= 1'b0;
      anodes_q    <= '1;
      segments_q  <= '1;
      leds_q      <= '0;
      k_q         <= '0;
      scan_cnt_q  <= '0;
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
      step_cnt_q  <= '0;
      p_q         <= '0;
      alarm_q     <= 1'b0;
    end else begin
      h1_q        <= h1_d;
      h0_q        <= h0_d;
      m1_q        <= time_bcd[15:12];
      m0_q        <= time_bcd[11:8];
      s1_q        <= time_bcd[7:4];
      s0_q        <= time_bcd[3:0];
      pm_q        <= pm_d;
      mode_q      <= mod12_24;
      anodes_q    <= anodes_d;
      segments_q  <= segments_d;
      leds_q      <= leds_d;
      k_q         <= k_d;
      scan_cnt_q  <= scan_cnt_d;
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
      step_cnt_q  <= step_cnt_d;
      p_q         <= p_d;
      alarm_q     <= alarm;
    end
  end

  assign anodes   = anodes_q;
  assign segments = segments_q;
  assign leds     = leds_q;

endmodule

// File: tb/tb_multi_time_display.sv
// Directed bench for multi_time_display: a 6-digit and a 4-digit instance share stimulus.
module tb_multi_time_display;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mod12_24 = 1'b0;
  logic        alarm = 1'b0;
  logic [1:0]  edit_field = 2'd0;
  logic [23:0] time_bcd = 24'h235959;
  logic [5:0]  an6;
  logic [3:0]  an4;
  logic [7:0]  seg6, seg4, leds6, leds4;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  multi_time_display #(
    .N_DIGITS(6), .N_LEDS(8), .SCAN_DIV(4), .BLINK_DIV(16), .STEP_DIV(3)
  ) dut6 (
    .clk(clk), .reset(reset), .mod12_24(mod12_24), .alarm(alarm), .edit_field(edit_field),
    .time_bcd(time_bcd), .anodes(an6), .segments(seg6), .leds(leds6)
  );

  multi_time_display #(
    .N_DIGITS(4), .N_LEDS(8), .SCAN_DIV(4), .BLINK_DIV(16), .STEP_DIV(3)
  ) dut4 (
    .clk(clk), .reset(reset), .mod12_24(mod12_24), .alarm(alarm), .edit_field(edit_field),
    .time_bcd(time_bcd), .anodes(an4), .segments(seg4), .leds(leds4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_time(input logic mode, input logic [23:0] t);
    mod12_24 = mode;
    time_bcd = t;
    tick();
    tick();
    tick();
  endtask

  // Waits (bounded) for the 6-digit scan to reach digit k, then checks its segments.
  task automatic check_dig(input string tag, input int k, input logic [7:0] exp,
                           input logic [7:0] mask);
    logic [5:0] want;
    int n;
    want = ~(6'd1 << k);
    n = 0;
    while (an6 !== want && n < 30) begin
      tick();
      n++;
    end
    chk({tag, "_scan"}, {2'b00, an6}, {2'b00, want});
    chk(tag, seg6 & mask, exp);
  endtask

  initial begin
    logic [7:0] vis [6];
    logic [7:0] vis4 [4];
    logic [7:0] e;
    logic [5:0] a6;
    logic [3:0] a4;
    int k6, k4, ph;

    tick();
    tick();
    tick();
    chk("rst_an6", {2'b00, an6}, 8'h3F);
    chk("rst_seg6", seg6, 8'hFF);
    chk("rst_leds6", leds6, 8'h00);
    chk("rst_an4", {4'h0, an4}, 8'h0F);

    // Release and follow the scan over two full 6-digit rotations.
    reset = 1'b0;
    cyc = 0;
    for (int i = 0; i < 48; i++) begin
      tick();
      k6 = ((cyc - 1) / 4) % 6;
      k4 = ((cyc - 1) / 4) % 4;
      a6 = ~(6'd1 << k6);
      a4 = ~(4'd1 << k4);
      chk("scan_an6", {2'b00, an6}, {2'b00, a6});
      chk("scan_an4", {4'h0, an4}, {4'h0, a4});
      if (cyc == 1) begin
        chk("first_seg6", seg6, 8'hC0);
        chk("first_seg4", seg4, 8'h40);
      end
      if (cyc == 2) begin
        chk("lat_seg6", seg6, 8'h90);
        chk("lat_seg4", seg4, 8'h10);
      end
    end

    // 24h display of 23:59:59
    check_dig("s0_9", 0, 8'h90, 8'hFF);
    check_dig("h1_2", 5, 8'hA4, 8'hFF);
    check_dig("h0_3", 4, 8'h30, 8'h7F);
    chk("pm_24h", leds6, 8'h00);

    // 12h conversion
    set_time(1'b1, 24'h005959);
    check_dig("h00_h1", 5, 8'hF9, 8'hFF);
    check_dig("h00_h0", 4, 8'h24, 8'h7F);
    chk("h00_pm", leds6, 8'h00);
    set_time(1'b1, 24'h135959);
    check_dig("h13_h1", 5, 8'hFF, 8'hFF);
    check_dig("h13_h0", 4, 8'h79, 8'h7F);
    chk("h13_pm", leds6, 8'h01);
    set_time(1'b1, 24'h125959);
    check_dig("h12_h1", 5, 8'hF9, 8'hFF);
    check_dig("h12_h0", 4, 8'h24, 8'h7F);
    chk("h12_pm", leds6, 8'h01);
    set_time(1'b1, 24'h095959);
    check_dig("h09_h1", 5, 8'hFF, 8'hFF);
    check_dig("h09_h0", 4, 8'h10, 8'h7F);
    chk("h09_pm", leds6, 8'h00);
    set_time(1'b1, 24'h235959);
    check_dig("h23_h1", 5, 8'hF9, 8'hFF);
    check_dig("h23_h0", 4, 8'h79, 8'h7F);
    chk("h23_pm", leds6, 8'h01);
    set_time(1'b1, 24'h205959);
    check_dig("h20_h1", 5, 8'hFF, 8'hFF);
    check_dig("h20_h0", 4, 8'h00, 8'h7F);
    chk("h20_pm", leds6, 8'h01);

    // Colon blink with no edit field: dp on H0/M0 only in the visible phase.
    set_time(1'b0, 24'h235959);
    vis = '{8'h90, 8'h92, 8'h90, 8'h92, 8'hB0, 8'hA4};
    for (int i = 0; i < 48; i++) begin
      tick();
      k6 = ((cyc - 1) / 4) % 6;
      ph = ((cyc - 1) / 16) % 2;
      e = vis[k6];
      if ((k6 == 2 || k6 == 4) && ph == 0) e[7] = 1'b0;
      chk("colon", seg6, e);
    end

    // Minutes edit field blinks; colon steady.
    edit_field = 2'd2;
    tick();
    tick();
    vis = '{8'h90, 8'h92, 8'h10, 8'h92, 8'h30, 8'hA4};
    for (int i = 0; i < 64; i++) begin
      tick();
      k6 = ((cyc - 1) / 4) % 6;
      ph = ((cyc - 1) / 16) % 2;
      e = ((k6 == 2 || k6 == 3) && ph == 1) ? 8'hFF : vis[k6];
      chk("edit_min", seg6, e);
    end

    // Alarm chaser
    edit_field = 2'd0;
    set_time(1'b1, 24'h095959);
    chk("alm_idle", leds6, 8'h00);
    alarm = 1'b1;
    tick();
    chk("alm_lat1", leds6, 8'h00);
    for (int j = 0; j < 27; j++) begin
      tick();
      e = 8'd1 << ((j / 3) % 8);
      chk("chase", leds6, e);
    end
    alarm = 1'b0;
    tick();
    chk("alm_fall1", leds6, 8'h02);
    tick();
    chk("alm_fall2", leds6, 8'h00);

    // Single-cycle alarm pulse
    alarm = 1'b1;
    tick();
    chk("pulse_1", leds6, 8'h00);
    alarm = 1'b0;
    tick();
    chk("pulse_2", leds6, 8'h01);
    tick();
    chk("pulse_3", leds6, 8'h00);

    // Reset mid-chase at scan digit 3
    alarm = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    begin
      int n;
      n = 0;
      while (an6 !== 6'b110111 && n < 30) begin
        tick();
        n++;
      end
    end
    chk("pre_rst_k3", {2'b00, an6}, 8'h37);
    reset = 1'b1;
    tick();
    chk("mid_rst_an6", {2'b00, an6}, 8'h3F);
    chk("mid_rst_seg6", seg6, 8'hFF);
    chk("mid_rst_leds6", leds6, 8'h00);
    chk("mid_rst_an4", {4'h0, an4}, 8'h0F);
    chk("mid_rst_seg4", seg4, 8'hFF);
    reset = 1'b0;
    cyc = 0;
    tick();
    chk("rel_an6", {2'b00, an6}, 8'h3E);
    chk("rel_leds1", leds6, 8'h00);
    tick();
    chk("rel_leds2", leds6, 8'h01);
    chk("rel_an6_2", {2'b00, an6}, 8'h3E);
    alarm = 1'b0;

    // Seconds edit field: 4-digit bank never blanks; 6-digit bank blanks S1/S0.
    edit_field = 2'd3;
    set_time(1'b0, 24'h235959);
    vis4 = '{8'h10, 8'h92, 8'h30, 8'hA4};
    for (int i = 0; i < 40; i++) begin
      tick();
      k4 = ((cyc - 1) / 4) % 4;
      k6 = ((cyc - 1) / 4) % 6;
      ph = ((cyc - 1) / 16) % 2;
      a4 = ~(4'd1 << k4);
      chk("d4_an", {4'h0, an4}, {4'h0, a4});
      chk("d4_seg", seg4, vis4[k4]);
      e = (k6 <= 1 && ph == 1) ? 8'hFF : vis[k6];
      chk("d6_edit_sec", seg6, e);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
